mdu_control: RTL

Parametrised multiply/divide control and sequencing unit for the EX stage, alongside the ALU control decoder. Decodes R-type funct codes when the control unit signals R-type (`UCon` = 2'b10). Runs iterative multiply and divide operations over a start/busy/done handshake and holds the HI/LO architectural registers. Serves mfhi/mflo reads to the writeback path and raises `stall` to hold the pipeline while an operation is in flight.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_iter_step.sv | 51 +++++
 rtl/mdu_control.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : funct codes, control-unit encoding and FSM states for mdu_control
// Rev 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] UCON_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
// mdu_iter_step : one shift-add or restoring-subtract iteration on {acc, q}
// Divider path present only with MDU_DIV_EN.  Rev 1.0
// ============================================================================
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             sel_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    // Multiply: q holds the multiplier, the product shifts right into q.
    logic [WIDTH:0] w_sum;
    assign w_sum = q[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};

`ifdef MDU_DIV_EN
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // acc stays below the divisor, so the diff MSB is a clean borrow flag.
    assign w_shl    = {acc, q[WIDTH-1]};
    assign w_diff   = w_shl - {1'b0, opnd};
    assign w_borrow = w_diff[WIDTH];

    always_comb begin
        acc_nxt = w_sum[WIDTH:1];
        q_nxt   = {w_sum[0], q[WIDTH-1:1]};
        if (sel_div) begin
            acc_nxt = w_borrow ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], ~w_borrow};
        end
    end
`else
    always_comb begin
        acc_nxt = w_sum[WIDTH:1];
        q_nxt   = {w_sum[0], q[WIDTH-1:1]};
        if (sel_div) begin
            acc_nxt = acc;
            q_nxt   = q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mdu_control.sv
`default_nettype none
// ============================================================================
// mdu_control : EX-stage multiply/divide sequencer with HI/LO and handshake
// Optional divider datapath: define MDU_DIV_EN.  Rev 1.0
// ============================================================================
module mdu_control
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       UCon,
    input  logic [5:0]       InData,
    input  logic             start,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_hi;
    logic               r_done;
    logic               r_illegal;
`ifdef MDU_DIV_EN
    logic               r_neg_lo;
    logic               r_is_mul;
    logic               w_div_zero;
`endif

    logic               w_rtype;
    logic               w_is_mdu;
    logic               w_accept;
    logic               w_busy;
    logic               w_sel_div;
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_q_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_rtype  = (UCon == UCON_RTYPE);
    assign w_is_mdu = w_rtype & is_mdu_funct(InData);

    // Signed ops run on magnitudes; result signs are restored in FIX.
    assign w_signed = (InData == F_MULT) || (InData == F_DIV);
    assign w_rs_neg = w_signed & rs_data[WIDTH-1];
    assign w_rt_neg = w_signed & rt_data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;
`ifdef MDU_DIV_EN
    assign w_div_zero = (rt_data == '0);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (InData)
                        F_MULT, F_MULTU: w_state_nxt = S_MUL;
`ifdef MDU_DIV_EN
                        F_DIV, F_DIVU:   w_state_nxt = w_div_zero ? S_FIX : S_DIV;
`endif
                        default:         w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == '0) w_state_nxt = S_FIX;
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                if (r_cnt == '0) w_state_nxt = S_FIX;
            end
`endif
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_accept  = start & w_is_mdu & (r_state == S_IDLE);
        w_sel_div = (r_state == S_DIV);
        stall     = w_busy & start & w_is_mdu;
    end

    mdu_iter_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .sel_div (w_sel_div),
        .acc     (r_acc),
        .q       (r_q),
        .opnd    (r_opnd),
        .acc_nxt (w_acc_step),
        .q_nxt   (w_q_step)
    );

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_hi ? -w_prod : w_prod;

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (!r_is_mul) begin
            w_fix_hi = r_neg_hi ? -r_acc : r_acc;
            w_fix_lo = r_neg_lo ? -r_q : r_q;
        end
`endif
    end

    // ---------------- datapath, HI/LO and pulses ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_hi  <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef MDU_DIV_EN
            r_neg_lo  <= 1'b0;
            r_is_mul  <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (InData)
                            F_MTHI: begin
                                r_hi   <= rs_data;
                                r_done <= 1'b1;
                            end
                            F_MTLO: begin
                                r_lo   <= rs_data;
                                r_done <= 1'b1;
                            end
                            F_MULT, F_MULTU: begin
                                r_acc    <= '0;
                                r_q      <= w_rt_mag;
                                r_opnd   <= w_rs_mag;
                                r_neg_hi <= w_rs_neg ^ w_rt_neg;
                                r_cnt    <= CNT_W'(WIDTH - 1);
`ifdef MDU_DIV_EN
                                r_is_mul <= 1'b1;
`endif
                            end
                            F_DIV, F_DIVU: begin
`ifdef MDU_DIV_EN
                                r_is_mul <= 1'b0;
                                if (w_div_zero) begin
                                    // FIX passes acc/q straight through to HI/LO.
                                    r_acc    <= rs_data;
                                    r_q      <= '1;
                                    r_neg_hi <= 1'b0;
                                    r_neg_lo <= 1'b0;
                                end else begin
                                    r_acc    <= '0;
                                    r_q      <= w_rs_mag;
                                    r_opnd   <= w_rt_mag;
                                    r_neg_hi <= w_rs_neg;
                                    r_neg_lo <= w_rs_neg ^ w_rt_neg;
                                    r_cnt    <= CNT_W'(WIDTH - 1);
                                end
`else
                                r_illegal <= 1'b1;
                                r_done    <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_acc_step;
                    r_q   <= w_q_step;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        if (w_rtype && (InData == F_MFHI)) begin
            result = r_hi;
        end else if (w_rtype && (InData == F_MFLO)) begin
            result = r_lo;
        end
    end

    assign busy    = w_busy;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire
